// File: rtl/tag_sync_ctrl.sv
// Tag sequencer for the double-buffered datapath: allocates tags round-robin
// for NEW/REUSE/FLUSH block commands, pulses the per-tag FSM controls, and
// steers the shared ldmem/compute/stmem handshakes to each stage's owning tag.
module tag_sync_ctrl #(
  parameter int NUM_TAGS      = 2,
  parameter int TAG_W         = $clog2(NUM_TAGS),
  parameter bit STORE_ENABLED = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd_type,
  input  logic                cmd_bias_prev_sw,
  input  logic                cmd_ddr_pe_sw,
  output logic                cmd_ready,
  output logic [NUM_TAGS-1:0] tag_req,
  output logic [NUM_TAGS-1:0] tag_reuse,
  output logic [NUM_TAGS-1:0] tag_flush,
  output logic                tag_bias_prev_sw,
  output logic                tag_ddr_pe_sw,
  input  logic [NUM_TAGS-1:0] tag_ready,
  input  logic [NUM_TAGS-1:0] ldmem_tag_ready_v,
  output logic [NUM_TAGS-1:0] ldmem_tag_done_v,
  output logic                ldmem_tag_ready,
  input  logic                ldmem_tag_done,
  output logic [TAG_W-1:0]    ldmem_tag,
  input  logic [NUM_TAGS-1:0] compute_tag_ready_v,
  input  logic [NUM_TAGS-1:0] next_compute_tag_v,
  output logic [NUM_TAGS-1:0] compute_tag_done_v,
  output logic [NUM_TAGS-1:0] next_sync_compute_tag,
  output logic                compute_tag_ready,
  input  logic                compute_tag_done,
  output logic [TAG_W-1:0]    compute_tag,
  input  logic [NUM_TAGS-1:0] stmem_tag_ready_v,
  output logic [NUM_TAGS-1:0] stmem_tag_done_v,
  output logic                stmem_tag_ready,
  input  logic                stmem_tag_done,
  output logic [TAG_W-1:0]    stmem_tag
);

  typedef enum logic [1:0] {
    CMD_NEW   = 2'd0,
    CMD_REUSE = 2'd1,
    CMD_FLUSH = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_e;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_OPEN  = 1'b1
  } state_e;

  state_e state, state_nxt;

  logic [TAG_W-1:0]    al_ptr, ld_ptr, cp_ptr, st_ptr, open_tag;
  logic                ready_c, accept, load_sw, alloc;
  logic [NUM_TAGS-1:0] req_nxt, reuse_nxt, flush_nxt;
  logic                ld_fire, cp_adv, cp_fire, st_fire;

  function automatic logic [NUM_TAGS-1:0] onehot(input logic [TAG_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_nxt;
  end

  // Command acceptance, next state and next pulse values
  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    req_nxt   = '0;
    reuse_nxt = '0;
    flush_nxt = '0;
    load_sw   = 1'b0;
    alloc     = 1'b0;
    unique case (cmd_e'(cmd_type))
      CMD_NEW:   ready_c = (state == S_EMPTY) && tag_ready[al_ptr];
      CMD_REUSE: ready_c = (state == S_OPEN);
      CMD_FLUSH: ready_c = (state == S_OPEN);
      CMD_RSVD:  ready_c = 1'b1;
    endcase
    accept = cmd_valid & ready_c;
    if (accept) begin
      unique case (cmd_e'(cmd_type))
        CMD_NEW: begin
          req_nxt   = onehot(al_ptr);
          load_sw   = 1'b1;
          alloc     = 1'b1;
          state_nxt = S_OPEN;
        end
        CMD_REUSE: begin
          reuse_nxt = onehot(open_tag);
          load_sw   = 1'b1;
        end
        CMD_FLUSH: begin
          flush_nxt = onehot(open_tag);
          state_nxt = S_EMPTY;
        end
        CMD_RSVD: ;
      endcase
    end
  end

  // Registered tag pulses, broadcast flags and allocation pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_req          <= '0;
      tag_reuse        <= '0;
      tag_flush        <= '0;
      tag_bias_prev_sw <= 1'b0;
      tag_ddr_pe_sw    <= 1'b0;
      al_ptr           <= '0;
      open_tag         <= '0;
    end else begin
      tag_req   <= req_nxt;
      tag_reuse <= reuse_nxt;
      tag_flush <= flush_nxt;
      if (load_sw) begin
        tag_bias_prev_sw <= cmd_bias_prev_sw;
        tag_ddr_pe_sw    <= cmd_ddr_pe_sw;
      end
      if (alloc) begin
        open_tag <= al_ptr;
        al_ptr   <= al_ptr + TAG_W'(1);
      end
    end
  end

  // Stage advance conditions; a done without the owning tag's ready is dropped
  always_comb begin
    ld_fire = ldmem_tag_done & ldmem_tag_ready_v[ld_ptr];
    cp_adv  = next_compute_tag_v[cp_ptr];
    cp_fire = compute_tag_done & compute_tag_ready_v[cp_ptr];
    st_fire = STORE_ENABLED & stmem_tag_done & stmem_tag_ready_v[st_ptr];
  end

  // Stage pointers; compute advances only on retire, not per reuse pass
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_ptr <= '0;
      cp_ptr <= '0;
      st_ptr <= '0;
    end else begin
      if (ld_fire) ld_ptr <= ld_ptr + TAG_W'(1);
      if (cp_adv)  cp_ptr <= cp_ptr + TAG_W'(1);
      if (st_fire) st_ptr <= st_ptr + TAG_W'(1);
    end
  end

  // Combinational steering, forced low while reset is asserted
  always_comb begin
    cmd_ready             = ready_c & ~reset;
    ldmem_tag             = ld_ptr;
    ldmem_tag_ready       = ldmem_tag_ready_v[ld_ptr] & ~reset;
    ldmem_tag_done_v      = (ld_fire & ~reset) ? onehot(ld_ptr) : '0;
    compute_tag           = cp_ptr;
    compute_tag_ready     = compute_tag_ready_v[cp_ptr] & ~reset;
    compute_tag_done_v    = (cp_fire & ~reset) ? onehot(cp_ptr) : '0;
    next_sync_compute_tag = {NUM_TAGS{cp_adv & ~reset}};
    stmem_tag             = st_ptr;
    stmem_tag_ready       = STORE_ENABLED & stmem_tag_ready_v[st_ptr] & ~reset;
    stmem_tag_done_v      = (st_fire & ~reset) ? onehot(st_ptr) : '0;
  end

endmodule

// File: tb/tb_tag_sync_ctrl.sv
// Randomized bench for tag_sync_ctrl against a behavioural tag/pointer model.
module tb_tag_sync_ctrl;

  localparam int N  = 2;
  localparam int TW = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [1:0]    cmd_type;
  logic          cmd_bias_prev_sw, cmd_ddr_pe_sw;
  logic          cmd_ready;
  logic [N-1:0]  tag_req, tag_reuse, tag_flush;
  logic          tag_bias_prev_sw, tag_ddr_pe_sw;
  logic [N-1:0]  tag_ready;
  logic [N-1:0]  ldmem_tag_ready_v, ldmem_tag_done_v;
  logic          ldmem_tag_ready, ldmem_tag_done;
  logic [TW-1:0] ldmem_tag;
  logic [N-1:0]  compute_tag_ready_v, next_compute_tag_v, compute_tag_done_v, next_sync_compute_tag;
  logic          compute_tag_ready, compute_tag_done;
  logic [TW-1:0] compute_tag;
  logic [N-1:0]  stmem_tag_ready_v, stmem_tag_done_v;
  logic          stmem_tag_ready, stmem_tag_done;
  logic [TW-1:0] stmem_tag;

  tag_sync_ctrl #(.NUM_TAGS(N), .TAG_W(TW), .STORE_ENABLED(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_bias_prev_sw(cmd_bias_prev_sw), .cmd_ddr_pe_sw(cmd_ddr_pe_sw),
    .cmd_ready(cmd_ready),
    .tag_req(tag_req), .tag_reuse(tag_reuse), .tag_flush(tag_flush),
    .tag_bias_prev_sw(tag_bias_prev_sw), .tag_ddr_pe_sw(tag_ddr_pe_sw),
    .tag_ready(tag_ready),
    .ldmem_tag_ready_v(ldmem_tag_ready_v), .ldmem_tag_done_v(ldmem_tag_done_v),
    .ldmem_tag_ready(ldmem_tag_ready), .ldmem_tag_done(ldmem_tag_done), .ldmem_tag(ldmem_tag),
    .compute_tag_ready_v(compute_tag_ready_v), .next_compute_tag_v(next_compute_tag_v),
    .compute_tag_done_v(compute_tag_done_v), .next_sync_compute_tag(next_sync_compute_tag),
    .compute_tag_ready(compute_tag_ready), .compute_tag_done(compute_tag_done), .compute_tag(compute_tag),
    .stmem_tag_ready_v(stmem_tag_ready_v), .stmem_tag_done_v(stmem_tag_done_v),
    .stmem_tag_ready(stmem_tag_ready), .stmem_tag_done(stmem_tag_done), .stmem_tag(stmem_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: open flag, open tag, and four round-robin pointers as plain integers
  int m_open, m_otag, m_al, m_ld, m_cp, m_st;
  logic [N-1:0] e_req, e_reuse, e_flush;
  logic e_bias, e_ddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_open = 0; m_otag = 0; m_al = 0; m_ld = 0; m_cp = 0; m_st = 0;
    e_req = '0; e_reuse = '0; e_flush = '0; e_bias = 1'b0; e_ddr = 1'b0;
  endtask

  task automatic zero_inputs();
    cmd_valid = 0; cmd_type = 2'd0; cmd_bias_prev_sw = 0; cmd_ddr_pe_sw = 0;
    tag_ready = '0; ldmem_tag_ready_v = '0; ldmem_tag_done = 0;
    compute_tag_ready_v = '0; next_compute_tag_v = '0; compute_tag_done = 0;
    stmem_tag_ready_v = '0; stmem_tag_done = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    zero_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  // Every output must read zero while reset is held, whatever the inputs
  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_tag_req"}, 32'(tag_req), 0);
    chk({tag, "_tag_reuse"}, 32'(tag_reuse), 0);
    chk({tag, "_tag_flush"}, 32'(tag_flush), 0);
    chk({tag, "_bias_ddr"}, 32'({tag_bias_prev_sw, tag_ddr_pe_sw}), 0);
    chk({tag, "_ld"}, 32'({ldmem_tag_done_v, ldmem_tag_ready, ldmem_tag}), 0);
    chk({tag, "_cp"}, 32'({compute_tag_done_v, next_sync_compute_tag, compute_tag_ready, compute_tag}), 0);
    chk({tag, "_st"}, 32'({stmem_tag_done_v, stmem_tag_ready, stmem_tag}), 0);
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs
  task automatic step();
    logic er, ld_go, cp_go, st_go, acc;
    logic [N-1:0] n_req, n_reuse, n_flush;
    #1;
    case (cmd_type)
      2'd0:    er = (m_open == 0) && tag_ready[m_al];
      2'd1:    er = (m_open == 1);
      2'd2:    er = (m_open == 1);
      default: er = 1'b1;
    endcase
    ld_go = ldmem_tag_done && ldmem_tag_ready_v[m_ld];
    cp_go = compute_tag_done && compute_tag_ready_v[m_cp];
    st_go = stmem_tag_done && stmem_tag_ready_v[m_st];
    chk("cmd_ready", 32'(cmd_ready), 32'(er));
    chk("ldmem_tag", 32'(ldmem_tag), 32'(m_ld));
    chk("ldmem_tag_ready", 32'(ldmem_tag_ready), 32'(ldmem_tag_ready_v[m_ld]));
    chk("ldmem_tag_done_v", 32'(ldmem_tag_done_v), ld_go ? (32'd1 << m_ld) : 32'd0);
    chk("compute_tag", 32'(compute_tag), 32'(m_cp));
    chk("compute_tag_ready", 32'(compute_tag_ready), 32'(compute_tag_ready_v[m_cp]));
    chk("compute_tag_done_v", 32'(compute_tag_done_v), cp_go ? (32'd1 << m_cp) : 32'd0);
    chk("next_sync_compute_tag", 32'(next_sync_compute_tag), next_compute_tag_v[m_cp] ? 32'((1 << N) - 1) : 32'd0);
    chk("stmem_tag", 32'(stmem_tag), 32'(m_st));
    chk("stmem_tag_ready", 32'(stmem_tag_ready), 32'(stmem_tag_ready_v[m_st]));
    chk("stmem_tag_done_v", 32'(stmem_tag_done_v), st_go ? (32'd1 << m_st) : 32'd0);

    acc = cmd_valid && er;
    n_req = '0; n_reuse = '0; n_flush = '0;
    if (acc) begin
      case (cmd_type)
        2'd0: begin
          n_req = N'(1 << m_al);
          m_otag = m_al; m_al = (m_al + 1) % N; m_open = 1;
          e_bias = cmd_bias_prev_sw; e_ddr = cmd_ddr_pe_sw;
        end
        2'd1: begin
          n_reuse = N'(1 << m_otag);
          e_bias = cmd_bias_prev_sw; e_ddr = cmd_ddr_pe_sw;
        end
        2'd2: begin
          n_flush = N'(1 << m_otag);
          m_open = 0;
        end
        default: ;
      endcase
    end
    if (ld_go) m_ld = (m_ld + 1) % N;
    if (next_compute_tag_v[m_cp]) m_cp = (m_cp + 1) % N;
    if (st_go) m_st = (m_st + 1) % N;
    e_req = n_req; e_reuse = n_reuse; e_flush = n_flush;

    @(posedge clk);
    #1;
    chk("tag_req", 32'(tag_req), 32'(e_req));
    chk("tag_reuse", 32'(tag_reuse), 32'(e_reuse));
    chk("tag_flush", 32'(tag_flush), 32'(e_flush));
    chk("tag_bias_prev_sw", 32'(tag_bias_prev_sw), 32'(e_bias));
    chk("tag_ddr_pe_sw", 32'(tag_ddr_pe_sw), 32'(e_ddr));
  endtask

  task automatic cmd(input logic [1:0] t, input logic v);
    cmd_valid = v; cmd_type = t;
  endtask

  task automatic rand_inputs();
    int r;
    cmd_valid = ($urandom % 4) != 0;
    r = $urandom % 10;
    cmd_type = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
    cmd_bias_prev_sw = 1'($urandom);
    cmd_ddr_pe_sw    = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      tag_ready[i]          = ($urandom % 4) != 0;
      ldmem_tag_ready_v[i]  = 1'($urandom);
      compute_tag_ready_v[i] = 1'($urandom);
      next_compute_tag_v[i] = ($urandom % 4) == 0;
      stmem_tag_ready_v[i]  = 1'($urandom);
    end
    ldmem_tag_done   = 1'($urandom);
    compute_tag_done = 1'($urandom);
    stmem_tag_done   = 1'($urandom);
  endtask

  initial begin
    model_clear();
    do_reset();
    check_all_zero("reset");

    // NEW, FLUSH with both tags free
    tag_ready = 2'b11;
    cmd(2'd0, 1'b1); cmd_bias_prev_sw = 1'b1;
    #1 chk("t1_new_ready", 32'(cmd_ready), 1);
    step();
    chk("t1_req", 32'(tag_req), 32'h1);
    chk("t1_bias", 32'(tag_bias_prev_sw), 1);
    cmd(2'd2, 1'b1); cmd_bias_prev_sw = 1'b0;
    step();
    chk("t1_flush", 32'(tag_flush), 32'h1);
    chk("t1_bias_held", 32'(tag_bias_prev_sw), 1);
    // al_ptr is now 1: next NEW stalls on tag_ready[1]=0, then allocates tag 1
    tag_ready = 2'b01; cmd(2'd0, 1'b1);
    step();
    chk("t3_stall_req", 32'(tag_req), 0);
    tag_ready = 2'b10;
    step();
    chk("t3_req_tag1", 32'(tag_req), 32'h2);
    // NEW held while open stalls until FLUSH
    step();
    chk("t4_new_open_stall", 32'(tag_req), 0);
    cmd(2'd1, 1'b1);
    step();
    chk("t2_reuse_open1", 32'(tag_reuse), 32'h2);
    cmd(2'd2, 1'b1);
    step();
    chk("t4_flush_tag1", 32'(tag_flush), 32'h2);
    // REUSE / FLUSH in empty state are refused
    cmd(2'd1, 1'b1);
    #1 chk("t4_reuse_empty_ready", 32'(cmd_ready), 0);
    step();
    chk("t4_reuse_empty_pulse", 32'(tag_reuse), 0);
    cmd(2'd2, 1'b1);
    step();
    chk("t4_flush_empty_pulse", 32'(tag_flush), 0);
    cmd(2'd3, 1'b1);
    #1 chk("rsvd_ready", 32'(cmd_ready), 1);
    step();
    cmd(2'd0, 1'b0);

    // Compute pointer: done alone never moves it, retire does
    compute_tag_ready_v = 2'b11; compute_tag_done = 1'b1;
    repeat (3) step();
    chk("t2_cp_hold", 32'(compute_tag), 0);
    compute_tag_done = 1'b0; next_compute_tag_v = 2'b01;
    step();
    chk("t2_cp_adv", 32'(compute_tag), 1);
    next_compute_tag_v = 2'b00;

    // Load done gated by ready
    ldmem_tag_done = 1'b1; ldmem_tag_ready_v = 2'b00;
    #1 chk("t5_done_v_blocked", 32'(ldmem_tag_done_v), 0);
    step();
    chk("t5_ld_hold", 32'(ldmem_tag), 0);
    ldmem_tag_ready_v = 2'b01;
    #1 chk("t5_done_v", 32'(ldmem_tag_done_v), 32'h1);
    step();
    chk("t5_ld_adv", 32'(ldmem_tag), 1);
    ldmem_tag_done = 1'b0;

    // Reset with a pending pulse visible
    tag_ready = 2'b11; cmd(2'd0, 1'b1);
    step();
    reset = 1'b1;
    cmd_valid = 1; cmd_type = 2'd3; tag_ready = '1; ldmem_tag_ready_v = '1; ldmem_tag_done = 1;
    compute_tag_ready_v = '1; compute_tag_done = 1; next_compute_tag_v = '1;
    stmem_tag_ready_v = '1; stmem_tag_done = 1;
    #1 check_all_zero("t6");
    @(posedge clk);
    #1 check_all_zero("t6_edge");
    reset = 1'b0;
    model_clear();
    zero_inputs();

    // Randomized run with occasional mid-operation resets
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      if (($urandom % 300) == 0) begin
        reset = 1'b1;
        #1 check_all_zero("rnd_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
